// File: rtl/clk_div_pkg.sv
// Shared parameters, channel update modes and helpers for the clock-enable divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 26;
  localparam int DEFAULT_DIV_DEF = 1_000_000;

  // What a channel does at the coming edge, in priority order SYNC > HOLD > WRAP > COUNT.
  typedef enum logic [1:0] {
    CH_COUNT,
    CH_WRAP,
    CH_HOLD,
    CH_SYNC
  } ch_mode_e;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, shadowed divisor and registered tick / square-wave outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_nx;
  ch_mode_e         mode;

  // An idle channel (div=0) has no wrap edge, so it takes a pending divisor like a disabled one.
  always_comb begin
    mode = CH_COUNT;
    if (sync)
      mode = CH_SYNC;
    else if (!en || div == '0)
      mode = CH_HOLD;
    else if (cnt >= div - CNT_W'(1))
      mode = CH_WRAP;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      div     <= CNT_W'(DEFAULT_DIV);
      div_nx  <= CNT_W'(DEFAULT_DIV);
      tick    <= 1'b0;
      clk_out <= 1'b0;
      pend    <= 1'b0;
    end else begin
      unique case (mode)
        CH_SYNC: begin
          cnt     <= '0;
          tick    <= 1'b0;
          clk_out <= 1'b0;
          pend    <= 1'b0;
          div     <= we ? cfg_div : div_nx;
          div_nx  <= we ? cfg_div : div_nx;
        end
        CH_HOLD: begin
          tick <= 1'b0;
          if (pend) begin
            div  <= div_nx;
            pend <= 1'b0;
            cnt  <= '0;
          end else if (div == '0) begin
            cnt <= '0;
          end
        end
        CH_WRAP: begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_out <= ~clk_out;
          if (pend) begin
            div  <= div_nx;
            pend <= 1'b0;
          end
        end
        default: begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      endcase
      // A write in the apply cycle lands after the old shadow was consumed, so it stays pending.
      if (we && mode != CH_SYNC) begin
        div_nx <= cfg_div;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable generators sharing one clock domain.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        sync,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           cfg_pend
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  // Writes to channel numbers beyond NUM_CH match no decoder and fall away.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (ch_en[i]),
      .sync    (sync),
      .we      (we),
      .cfg_div (cfg_div),
      .tick    (tick[i]),
      .clk_out (clk_out[i]),
      .pend    (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank against an absolute-time reference model of each channel.
module tb_clk_div_bank;

  localparam int NCH   = 3;
  localparam int CW    = 8;
  localparam int DDIV  = 5;

  logic            clk_in = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_ch = '0;
  logic [CW-1:0]   cfg_div = '0;
  logic [NCH-1:0]  ch_en = '0;
  logic            sync = 1'b0;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  cfg_pend;

  int checks = 0;
  int errors = 0;

  // Reference state: a period starts at edge m_start and ends with a tick div edges later.
  int edge_n = 0;
  int m_div[NCH];
  int m_sh[NCH];
  int m_start[NCH];
  int m_ticks[NCH];
  bit m_pend[NCH];
  bit m_tick[NCH];

  clk_div_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .ch_en    (ch_en),
    .sync     (sync),
    .tick     (tick),
    .clk_out  (clk_out),
    .cfg_pend (cfg_pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic modelEdge();
    edge_n++;
    for (int i = 0; i < NCH; i++) begin
      bit w;
      w = cfg_we && (int'(cfg_ch) == i);
      if (rst) begin
        m_div[i] = DDIV; m_sh[i] = DDIV; m_pend[i] = 0;
        m_start[i] = edge_n; m_ticks[i] = 0; m_tick[i] = 0;
      end else if (sync) begin
        if (w) m_sh[i] = int'(cfg_div);
        m_div[i] = m_sh[i]; m_pend[i] = 0;
        m_start[i] = edge_n; m_ticks[i] = 0; m_tick[i] = 0;
      end else begin
        if (!ch_en[i] || m_div[i] == 0) begin
          m_tick[i] = 0;
          if (m_pend[i]) begin
            m_div[i] = m_sh[i]; m_pend[i] = 0; m_start[i] = edge_n;
          end else if (m_div[i] == 0) begin
            m_start[i] = edge_n;
          end else begin
            m_start[i]++;
          end
        end else if (edge_n - m_start[i] == m_div[i]) begin
          m_tick[i] = 1; m_ticks[i]++; m_start[i] = edge_n;
          if (m_pend[i]) begin
            m_div[i] = m_sh[i]; m_pend[i] = 0;
          end
        end else begin
          m_tick[i] = 0;
        end
        if (w) begin
          m_sh[i] = int'(cfg_div); m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic w, input logic [1:0] ch,
                               input logic [CW-1:0] d, input logic [NCH-1:0] en);
    logic [NCH-1:0] e_tick, e_clk, e_pend;
    rst = r; sync = s; cfg_we = w; cfg_ch = ch; cfg_div = d; ch_en = en;
    @(posedge clk_in);
    modelEdge();
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = m_tick[i];
      e_clk[i]  = m_ticks[i][0];
      e_pend[i] = m_pend[i];
    end
    checkOutput("tick", 32'(tick), 32'(e_tick));
    checkOutput("clk_out", 32'(clk_out), 32'(e_clk));
    checkOutput("cfg_pend", 32'(cfg_pend), 32'(e_pend));
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, en);
  endtask

  initial begin
    $display("[TB] clk_div_bank bench starting");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, 3'b111);

    // Default ratio, then a mid-period write and a write landing on a wrap edge.
    idle(6, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'd3, 3'b111);
    idle(1, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 8'd7, 3'b111);
    idle(12, 3'b111);

    // Sync with a write folded in, then idle divisor, divisor one and an out-of-range write.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 8'd4, 3'b111);
    idle(20, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'd0, 3'b111);
    idle(12, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'd1, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 8'd2, 3'b111);
    idle(8, 3'b111);

    // Disabled channel with a pending write, then reset mid-period with a write outstanding.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 8'd2, 3'b101);
    idle(5, 3'b101);
    idle(3, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 8'd9, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, 3'b111);
    idle(12, 3'b111);

    for (int k = 0; k < 3000; k++) begin
      logic          r, s, w;
      logic [1:0]    ch;
      logic [CW-1:0] d;
      logic [NCH-1:0] en;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 7) == 0);
      ch = 2'($urandom_range(0, 3));
      d  = CW'($urandom_range(0, 9));
      en = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : ch_en;
      if ($urandom_range(0, 49) == 0) en = '1;
      applyStimulus(r, s, w, ch, d, en);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent clock-enable generators replacing the single fixed-ratio slow-clock divider in the digital-clock design. Each channel divides `clk_in` by a runtime-programmable ratio. Each channel produces both a one-cycle `tick` enable and a 50%-duty `clk_out` square wave. Divisor changes are shadowed and applied glitch-free at period boundaries. The bank feeds the seconds counter, display multiplexer and blink logic from one clock domain.

## Interface

- `NUM_CH`, 4, number of independent channels (1..16)
- `CNT_W`, 26, counter and divisor width in bits
- `DEFAULT_DIV`, 1_000_000, divisor loaded into every channel at reset (must fit in `CNT_W`)
- `clk_in`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cfg_we`  in  1  configuration write strobe, one cycle
- `cfg_ch`  in  max(1,$clog2(NUM_CH))  target channel of write
- `cfg_div`  in  CNT_W  new divisor for target channel
- `ch_en`  in  NUM_CH  per-channel run enable
- `sync`  in  1  restart all channels in phase
- `tick`  out  NUM_CH  one-cycle pulse per divided period
- `clk_out`  out  NUM_CH  square wave, toggles on each tick
- `cfg_pend`  out  NUM_CH  divisor write accepted, not yet applied

## Operation

- Per channel: counter `cnt` (CNT_W), active divisor `div`, shadow `div_nx`, pending flag.
- Reset values: `cnt`=0, `div`=`div_nx`=DEFAULT_DIV, `tick`=0, `clk_out`=0, `cfg_pend`=0.
- Run (ch_en=1, div≥1):
  - At an edge with `cnt`==div−1: `cnt`←0, `tick`←1, `clk_out`←~`clk_out`.
  - Otherwise: `cnt`←cnt+1, `tick`←0.
- div=0: channel idle. `cnt` held at 0, `tick`=0, `clk_out` holds.
- div=1: `tick` constantly high, `clk_out` toggles every cycle.
- ch_en=0: `cnt` and `clk_out` hold, `tick`←0. Pending divisor applied immediately (`div`←`div_nx`, `cfg_pend`←0), `cnt`←0.
- cfg_we with `cfg_ch`<NUM_CH: `div_nx`←`cfg_div`, `cfg_pend`[ch]←1.
- cfg_we with `cfg_ch`≥NUM_CH: ignored.
- Pending divisor applied at the wrap edge: `div`←`div_nx`, `cfg_pend`←0.
- Write coinciding with wrap edge: the wrap consumes the old `div_nx`; the new value stays pending until the next wrap.
- Second write before apply: last write wins, single pending.
- sync (all channels, priority over wrap and cfg apply ordering):
  - Effect: `cnt`←0, `clk_out`←0, `tick`←0, pending applied.
  - cfg_we in the same cycle: the write is applied by the sync (new value active, `cfg_pend`=0).
- rst overrides everything, including mid-period and pending writes.

## Timing

- All outputs registered; no combinational input-to-output paths.
- After rst deasserts with en=1: first `tick` high in cycle div (counting the first post-reset edge as 1), then every div cycles.
- `clk_out` period = 2·div cycles, duty exactly 50%.
- `cfg_pend` rises one edge after cfg_we and falls on the apply edge.
- sync: the next tick comes div edges after the sync edge, identically on all enabled channels with equal div.
- Counter compare on div−1 with div≥1 only; no wrap beyond 2^CNT_W−1.

## Structure

- Package `clk_div_pkg`: `CNT_W` default, `DEFAULT_DIV`, channel-index width function.
- Sub-module `clk_div_channel`: one counter, shadow register and output flops. Generated NUM_CH times; the top decodes `cfg_ch` and fans out `sync`.

## Test plan

- NUM_CH=2, CNT_W=8, DEFAULT_DIV=5, en=11 after reset -> `tick` high on cycles 5,10,15; `clk_out` toggles each tick, period 10.
- Write div=3 to ch0 on cycle 7 -> `cfg_pend`[0]=1 until wrap at cycle 10; ticks then at 13,16; ch1 unchanged.
- Write on exact wrap cycle 10 -> old div used for period ending 15, new from then; `cfg_pend` high through 15.
- Channels at div 5 and 7, sync pulse at cycle 12 -> both `clk_out`=0; ticks at 17 and 19 resp.
- div=0 -> no ticks, `clk_out` frozen; div=1 -> `tick` constant 1; cfg_ch=3 ignored.
- rst asserted mid-period with pending write -> all outputs to reset values next edge; divisor back to DEFAULT_DIV.
